uart_cfg_transceiver: RTL and testbench
=======================================

// Module: uart_cfg_transceiver
// PURPOSE
//  Parametrised full-duplex UART and successor to the fixed 8N1 uart_top.
//  Configurable data width, parity mode and stop-bit count; 16x-oversampled RX with
//  glitch-rejecting start detect, parity and framing error flags.
//  Sits between the host register logic and the pins; TX and RX are independent.
// PARAMETERS
//  CLK_FREQ    1000000  system clock in Hz
//  BAUD_RATE   9600     line rate in baud
//  DATA_BITS   8        data bits per frame, legal 5..9
//  PARITY      0        0 none, 1 odd, 2 even
//  STOP_BITS   1        1 or 2
//  OVERSAMPLE  16       RX samples per bit, even, >=4
//  Derived: DIV = max(1, CLK_FREQ/(BAUD_RATE*OVERSAMPLE)) (floor);
//           BIT_CLKS = DIV*OVERSAMPLE. Defaults: DIV=6, BIT_CLKS=96.
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  rx         in   1          serial input, asynchronous, idles high
//  dintx      in   DATA_BITS  TX data, sampled when newd is accepted
//  newd       in   1          TX request (level), accepted only in TX IDLE
//  tx         out  1          serial output, idles high
//  doutrx     out  DATA_BITS  last received word, LSB = first bit received
//  donetx     out  1          1-cycle pulse at end of last stop bit
//  donerx     out  1          1-cycle pulse, doutrx and error flags valid
//  tx_busy    out  1          high from accept until donetx cycle inclusive
//  parity_err out  1          parity mismatch on last frame (0 when PARITY=0)
//  frame_err  out  1          a stop-bit sample was 0 on last frame
// BEHAVIOUR
//  Reset (async, rst_n=0): tx=1; doutrx=0; donetx=donerx=tx_busy=0;
//   parity_err=frame_err=0; both FSMs go to IDLE; RX synchronisers preset to 1.
//  Reset mid-frame aborts immediately; tx returns high in the same cycle.
//  TX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE; each bit lasts exactly BIT_CLKS clocks.
//   - IDLE with newd=1: latch dintx, set tx_busy.
//     tx=0 (start bit) from the next cycle; the bit counter restarts on accept.
//   - DATA: LSB first, DATA_BITS bits.
//     PARITY: odd -> ^data^1, even -> ^data.
//     STOP: STOP_BITS*BIT_CLKS clocks of 1.
//   - donetx is asserted in the final clock of the last stop bit; tx_busy drops the next cycle.
//   - newd while busy is ignored, not queued.
//     A held newd re-triggers in IDLE: exactly one idle clock (tx=1) between frames.
//  RX path: 2-FF synchroniser on rx; all decisions use the synchronised value.
//   FSM: IDLE->START->DATA->[PARITY]->STOP->(WAIT_HIGH)->IDLE.
//   - Oversample tick: DIV-clock divider, cleared on entry to START.
//   - IDLE: synced rx=0 -> START.
//     START: at tick OVERSAMPLE/2, rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, no donerx).
//   - Later samples every OVERSAMPLE ticks (bit centre).
//     Data shifts in LSB first; parity is checked against the received bits.
//   - STOP: each stop-bit sample checked; any 0 sets frame_err.
//   - donerx pulses 1 cycle at the centre sample of the last stop bit.
//     doutrx, parity_err and frame_err update in that same cycle.
//     They hold until the next donerx; errored frames still deliver data.
//   - After frame_err with rx still low (break): WAIT_HIGH until synced rx=1, then IDLE.
//   - RX is fully independent of TX; simultaneous donetx and donerx are legal.
// CONFIGURATION
//  UART_LOOPBACK_EN defined:
//   - Adds input port loopback (1 bit).
//   - When loopback=1, the RX synchroniser input is the internal TX serial line,
//     the pin tx is forced to 1, and the rx pin is ignored.
//   - When loopback=0, behaviour is identical to the macro being undefined.
//   - Toggling loopback mid-frame is undefined; only change it while both FSMs are IDLE.
//  UART_LOOPBACK_EN undefined: no loopback port; RX is always fed from rx.
// TESTING (defaults unless noted; BIT_CLKS=96)
//  1. 8N1 TX: newd=1, dintx=8'hA5 for 1 clk -> tx = 0,1,0,1,0,0,1,0,1 then stop 1,
//     96 clk/bit; donetx 1 cycle at clk 960 after accept; tx_busy high throughout.
//  2. 8N1 RX: drive 0x3C frame at 96 clk/bit -> one donerx, doutrx=8'h3C,
//     parity_err=frame_err=0.
//  3. DATA_BITS=7, PARITY=2, STOP_BITS=2: send 7'h55 with wrong parity bit ->
//     doutrx=7'h55, parity_err=1; next frame with correct parity clears it.
//  4. Framing and break: stop bit driven 0 -> donerx with frame_err=1; hold rx=0
//     for 2000 clk -> no further donerx until rx returns high and a new start arrives.
//  5. Glitch and reset: rx low for 30 clk only -> no donerx; assert rst_n=0
//     mid TX data bit -> tx=1 and tx_busy=0 immediately; the next newd sends a full frame.
//  6. UART_LOOPBACK_EN, loopback=1: send 8'hC3 -> tx pin stays 1; donerx with
//     doutrx=8'hC3 and no errors.

Source files
------------

// File: rtl/uart_cfg_transceiver_if.sv
// Host-side interface of uart_cfg_transceiver: TX request/data and RX data/status.
// The host is the master; the UART is the slave.
interface uart_cfg_transceiver_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] dintx;
   logic                 newd;
   logic [DATA_BITS-1:0] doutrx;
   logic                 donetx;
   logic                 donerx;
   logic                 tx_busy;
   logic                 parity_err;
   logic                 frame_err;

   modport master (
      output dintx, newd,
      input  doutrx, donetx, donerx, tx_busy, parity_err, frame_err
   );

   modport slave (
      input  dintx, newd,
      output doutrx, donetx, donerx, tx_busy, parity_err, frame_err
   );
endinterface

// File: rtl/uart_cfg_transceiver.sv
// Full-duplex UART with configurable data width, parity and stop bits; 16x-oversampled RX.
// Optional feature: define UART_LOOPBACK_EN to add the internal TX->RX loopback port.
module uart_cfg_transceiver #(
   parameter int CLK_FREQ   = 1000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef UART_LOOPBACK_EN
   input  logic                  loopback,
`endif
   input  logic                  rx,
   output logic                  tx,
   uart_cfg_transceiver_if.slave host
);

   localparam int DIV_RAW  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int BIT_CLKS = DIV * OVERSAMPLE;
   localparam int CW       = $clog2(BIT_CLKS);
   localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OW       = $clog2(OVERSAMPLE);

   localparam logic [2:0] TX_IDLE   = 3'd0;
   localparam logic [2:0] TX_START  = 3'd1;
   localparam logic [2:0] TX_DATA   = 3'd2;
   localparam logic [2:0] TX_PARITY = 3'd3;
   localparam logic [2:0] TX_STOP   = 3'd4;

   localparam logic [2:0] RX_IDLE      = 3'd0;
   localparam logic [2:0] RX_START     = 3'd1;
   localparam logic [2:0] RX_DATA      = 3'd2;
   localparam logic [2:0] RX_PARITY    = 3'd3;
   localparam logic [2:0] RX_STOP      = 3'd4;
   localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

   // ---------------------------------------------------------------- TX path
   logic [2:0]           tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [3:0]           tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0] tx_shr_q, tx_shr_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_line_q, tx_line_d;
   logic                 tx_bit_end;

   assign tx_bit_end = (tx_cnt_q == CW'(BIT_CLKS - 1));

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
      tx_idx_d   = tx_idx_q;
      tx_shr_d   = tx_shr_q;
      tx_par_d   = tx_par_q;
      tx_line_d  = tx_line_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d  = '0;
            tx_line_d = 1'b1;
            if (host.newd) begin
               tx_state_d = TX_START;
               tx_shr_d   = host.dintx;
               tx_par_d   = (PARITY == 1) ? ~^host.dintx : ^host.dintx;
               tx_idx_d   = '0;
               tx_line_d  = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_d = TX_DATA;
               tx_line_d  = tx_shr_q[0];
               tx_shr_d   = tx_shr_q >> 1;
               tx_idx_d   = '0;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               if (tx_idx_q == 4'(DATA_BITS - 1)) begin
                  tx_idx_d = '0;
                  if (PARITY != 0) begin
                     tx_state_d = TX_PARITY;
                     tx_line_d  = tx_par_q;
                  end else begin
                     tx_state_d = TX_STOP;
                     tx_line_d  = 1'b1;
                  end
               end else begin
                  tx_line_d = tx_shr_q[0];
                  tx_shr_d  = tx_shr_q >> 1;
                  tx_idx_d  = tx_idx_q + 4'd1;
               end
            end
         end
         TX_PARITY: begin
            if (tx_bit_end) begin
               tx_state_d = TX_STOP;
               tx_line_d  = 1'b1;
               tx_idx_d   = '0;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               if (tx_idx_q == 4'(STOP_BITS - 1)) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_idx_d = tx_idx_q + 4'd1;
               end
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_line_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shr_q   <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shr_q   <= tx_shr_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
      end
   end

   assign host.tx_busy = (tx_state_q != TX_IDLE);
   assign host.donetx  = (tx_state_q == TX_STOP) && tx_bit_end &&
                         (tx_idx_q == 4'(STOP_BITS - 1));

   // ---------------------------------------------------------------- RX path
   logic                 rx_src;
   logic                 rx_meta_q, rx_sync_q;
   logic [2:0]           rx_state_q, rx_state_d;
   logic [DW-1:0]        rx_div_q, rx_div_d;
   logic [OW-1:0]        rx_os_q, rx_os_d;
   logic [OW-1:0]        rx_os_target;
   logic [3:0]           rx_idx_q, rx_idx_d;
   logic [DATA_BITS-1:0] rx_shr_q, rx_shr_d;
   logic                 rx_perr_acc_q, rx_perr_acc_d;
   logic                 rx_ferr_acc_q, rx_ferr_acc_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic                 rx_done_q, rx_done_d;
   logic                 rx_tick, rx_sample;

`ifdef UART_LOOPBACK_EN
   assign rx_src = loopback ? tx_line_q : rx;
   assign tx     = loopback ? 1'b1 : tx_line_q;
`else
   assign rx_src = rx;
   assign tx     = tx_line_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_src;
         rx_sync_q <= rx_meta_q;
      end
   end

   // The start bit is qualified half a bit in; every later sample lands a full bit apart.
   assign rx_os_target = (rx_state_q == RX_START) ? OW'(OVERSAMPLE / 2 - 1) : OW'(OVERSAMPLE - 1);
   assign rx_tick      = (rx_div_q == DW'(DIV - 1));
   assign rx_sample    = rx_tick && (rx_os_q == rx_os_target);

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_div_d      = rx_tick ? '0 : rx_div_q + DW'(1);
      rx_os_d       = rx_tick ? (rx_sample ? '0 : rx_os_q + OW'(1)) : rx_os_q;
      rx_idx_d      = rx_idx_q;
      rx_shr_d      = rx_shr_q;
      rx_perr_acc_d = rx_perr_acc_q;
      rx_ferr_acc_d = rx_ferr_acc_q;
      rx_data_d     = rx_data_q;
      rx_perr_d     = rx_perr_q;
      rx_ferr_d     = rx_ferr_q;
      rx_done_d     = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_div_d = '0;
            rx_os_d  = '0;
            if (!rx_sync_q) begin
               rx_state_d    = RX_START;
               rx_perr_acc_d = 1'b0;
               rx_ferr_acc_d = 1'b0;
            end
         end
         RX_START: begin
            if (rx_sample) begin
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
               rx_idx_d   = '0;
            end
         end
         RX_DATA: begin
            if (rx_sample) begin
               rx_shr_d = {rx_sync_q, rx_shr_q[DATA_BITS-1:1]};
               if (rx_idx_q == 4'(DATA_BITS - 1)) begin
                  rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                  rx_idx_d   = '0;
               end else begin
                  rx_idx_d = rx_idx_q + 4'd1;
               end
            end
         end
         RX_PARITY: begin
            if (rx_sample) begin
               rx_perr_acc_d = (PARITY == 1) ? ~(^{rx_shr_q, rx_sync_q}) : ^{rx_shr_q, rx_sync_q};
               rx_state_d    = RX_STOP;
               rx_idx_d      = '0;
            end
         end
         RX_STOP: begin
            if (rx_sample) begin
               if (!rx_sync_q) begin
                  rx_ferr_acc_d = 1'b1;
               end
               if (rx_idx_q == 4'(STOP_BITS - 1)) begin
                  rx_done_d  = 1'b1;
                  rx_data_d  = rx_shr_q;
                  rx_perr_d  = rx_perr_acc_q;
                  rx_ferr_d  = rx_ferr_acc_q | ~rx_sync_q;
                  // A low line here is a break; wait for it to release before re-arming.
                  rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
               end else begin
                  rx_idx_d = rx_idx_q + 4'd1;
               end
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_sync_q) begin
               rx_state_d = RX_IDLE;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q    <= RX_IDLE;
         rx_div_q      <= '0;
         rx_os_q       <= '0;
         rx_idx_q      <= '0;
         rx_shr_q      <= '0;
         rx_perr_acc_q <= 1'b0;
         rx_ferr_acc_q <= 1'b0;
         rx_data_q     <= '0;
         rx_perr_q     <= 1'b0;
         rx_ferr_q     <= 1'b0;
         rx_done_q     <= 1'b0;
      end else begin
         rx_state_q    <= rx_state_d;
         rx_div_q      <= rx_div_d;
         rx_os_q       <= rx_os_d;
         rx_idx_q      <= rx_idx_d;
         rx_shr_q      <= rx_shr_d;
         rx_perr_acc_q <= rx_perr_acc_d;
         rx_ferr_acc_q <= rx_ferr_acc_d;
         rx_data_q     <= rx_data_d;
         rx_perr_q     <= rx_perr_d;
         rx_ferr_q     <= rx_ferr_d;
         rx_done_q     <= rx_done_d;
      end
   end

   assign host.doutrx     = rx_data_q;
   assign host.donerx     = rx_done_q;
   assign host.parity_err = rx_perr_q;
   assign host.frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_cfg_transceiver.sv
// Self-checking bench for uart_cfg_transceiver: a default 8N1 instance and a 7E2 instance.
// RX results are checked through per-instance scoreboards popped on donerx.
module tb_uart_cfg_transceiver;

   localparam int BIT_CLKS = 96;

   typedef struct packed {
      logic       ferr;
      logic       perr;
      logic [8:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   logic rx8, rx7;
   logic tx8, tx7;
   logic loopback;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int done8_cnt = 0;
   int done7_cnt = 0;

   exp_t q8[$];
   exp_t q7[$];
   exp_t e8, e7;

   uart_cfg_transceiver_if #(.DATA_BITS(8)) if8 ();
   uart_cfg_transceiver_if #(.DATA_BITS(7)) if7 ();

   uart_cfg_transceiver dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef UART_LOOPBACK_EN
      .loopback (loopback),
`endif
      .rx       (rx8),
      .tx       (tx8),
      .host     (if8)
   );

   uart_cfg_transceiver #(
      .DATA_BITS (7),
      .PARITY    (2),
      .STOP_BITS (2)
   ) dut7 (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef UART_LOOPBACK_EN
      .loopback (1'b0),
`endif
      .rx       (rx7),
      .tx       (tx7),
      .host     (if7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RX scoreboards: compare on every donerx pulse.
   always @(negedge clk) begin
      if (rst_n && if8.donerx === 1'b1) begin
         done8_cnt++;
         if (q8.size() == 0) begin
            chk_cnt++;
            $display("FAIL rx8_unexpected: donerx with nothing expected, doutrx=%h", if8.doutrx);
         end else begin
            e8 = q8.pop_front();
            chk_cnt++;
            if (if8.doutrx !== e8.data[7:0])
               $display("FAIL rx8_data: got %h want %h", if8.doutrx, e8.data[7:0]);
            else pass_cnt++;
            chk_cnt++;
            if (if8.parity_err !== e8.perr)
               $display("FAIL rx8_perr: got %b want %b", if8.parity_err, e8.perr);
            else pass_cnt++;
            chk_cnt++;
            if (if8.frame_err !== e8.ferr)
               $display("FAIL rx8_ferr: got %b want %b", if8.frame_err, e8.ferr);
            else pass_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && if7.donerx === 1'b1) begin
         done7_cnt++;
         if (q7.size() == 0) begin
            chk_cnt++;
            $display("FAIL rx7_unexpected: donerx with nothing expected, doutrx=%h", if7.doutrx);
         end else begin
            e7 = q7.pop_front();
            chk_cnt++;
            if (if7.doutrx !== e7.data[6:0])
               $display("FAIL rx7_data: got %h want %h", if7.doutrx, e7.data[6:0]);
            else pass_cnt++;
            chk_cnt++;
            if (if7.parity_err !== e7.perr)
               $display("FAIL rx7_perr: got %b want %b", if7.parity_err, e7.perr);
            else pass_cnt++;
            chk_cnt++;
            if (if7.frame_err !== e7.ferr)
               $display("FAIL rx7_ferr: got %b want %b", if7.frame_err, e7.ferr);
            else pass_cnt++;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives n bits LSB first, BIT_CLKS clocks each; optionally returns the line to idle.
   task automatic drive_rx(input bit sel7, input logic [15:0] bits, input int n,
                           input bit idle_after);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (sel7) rx7 = bits[i];
         else      rx8 = bits[i];
         repeat (BIT_CLKS - 1) @(negedge clk);
      end
      if (idle_after) begin
         @(negedge clk);
         if (sel7) rx7 = 1'b1;
         else      rx8 = 1'b1;
      end
   endtask

   task automatic rx8_frame(input logic [7:0] d, input logic stop, input bit idle_after);
      exp_t e;
      e.ferr = ~stop;
      e.perr = 1'b0;
      e.data = {1'b0, d};
      q8.push_back(e);
      drive_rx(1'b0, {6'b0, stop, d, 1'b0}, 10, idle_after);
   endtask

   task automatic rx7_frame(input logic [6:0] d, input logic par_flip);
      exp_t e;
      logic p;
      p      = (^d) ^ par_flip;
      e.ferr = 1'b0;
      e.perr = par_flip;
      e.data = {2'b0, d};
      q7.push_back(e);
      drive_rx(1'b1, {5'b0, 2'b11, p, d, 1'b0}, 11, 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++; if (tx8 !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx8); else pass_cnt++;
      chk_cnt++; if (tx7 !== 1'b1) $display("FAIL reset_tx7: got %b want 1", tx7); else pass_cnt++;
      chk_cnt++;
      if (if8.doutrx !== 8'h00) $display("FAIL reset_doutrx: got %h want 00", if8.doutrx);
      else pass_cnt++;
      chk_cnt++;
      if ({if8.donetx, if8.donerx, if8.tx_busy} !== 3'b000)
         $display("FAIL reset_pulses: got %b want 000", {if8.donetx, if8.donerx, if8.tx_busy});
      else pass_cnt++;
      chk_cnt++;
      if ({if8.parity_err, if8.frame_err} !== 2'b00)
         $display("FAIL reset_errs: got %b want 00", {if8.parity_err, if8.frame_err});
      else pass_cnt++;
      chk_cnt++;
      if ({if7.donetx, if7.tx_busy, if7.doutrx} !== 9'd0)
         $display("FAIL reset_dut7: got %h want 0", {if7.donetx, if7.tx_busy, if7.doutrx});
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_tx(input logic [7:0] d);
      logic [9:0] fr;
      int done_cnt, done_at;
      bit busy_low;
      fr = {1'b1, d, 1'b0};
      done_cnt = 0;
      done_at  = -1;
      busy_low = 1'b0;
      @(negedge clk);
      if8.dintx = d;
      if8.newd  = 1'b1;
      @(posedge clk);
      #1 if8.newd = 1'b0;
      for (int n = 0; n <= BIT_CLKS * 10; n++) begin
         @(negedge clk);
         if (n < BIT_CLKS * 10 && (n % BIT_CLKS) == BIT_CLKS / 2) begin
            chk_cnt++;
            if (tx8 !== fr[n / BIT_CLKS])
               $display("FAIL tx_bit%0d: got %b want %b", n / BIT_CLKS, tx8, fr[n / BIT_CLKS]);
            else pass_cnt++;
         end
         if (n < BIT_CLKS * 10 && if8.tx_busy !== 1'b1) busy_low = 1'b1;
         if (if8.donetx === 1'b1) begin
            done_cnt++;
            done_at = n;
         end
         if (n == BIT_CLKS * 10) begin
            chk_cnt++;
            if (if8.tx_busy !== 1'b0) $display("FAIL tx_busy_drop: got %b want 0", if8.tx_busy);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (busy_low) $display("FAIL tx_busy_hold: got low during frame want high");
      else pass_cnt++;
      chk_cnt++;
      if (done_cnt != 1 || done_at != BIT_CLKS * 10 - 1)
         $display("FAIL tx_donetx: got %0d pulses at %0d want 1 at %0d",
                  done_cnt, done_at, BIT_CLKS * 10 - 1);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int done_cnt, done_at;
      done_cnt = 0;
      done_at  = -1;
      @(negedge clk);
      if8.dintx = 8'h5A;
      if8.newd  = 1'b1;
      @(posedge clk);
      for (int n = 0; n <= 1930; n++) begin
         @(negedge clk);
         if (n == 959) begin
            chk_cnt++;
            if (if8.donetx !== 1'b1) $display("FAIL b2b_done1: got %b want 1", if8.donetx);
            else pass_cnt++;
         end
         if (n == 960) begin
            chk_cnt++;
            if ({tx8, if8.tx_busy} !== 2'b10)
               $display("FAIL b2b_gap: got tx/busy %b want 10", {tx8, if8.tx_busy});
            else pass_cnt++;
         end
         if (n == 961) begin
            chk_cnt++;
            if ({tx8, if8.tx_busy} !== 2'b01)
               $display("FAIL b2b_start: got tx/busy %b want 01", {tx8, if8.tx_busy});
            else pass_cnt++;
            if8.newd = 1'b0;
         end
         if (n == 961 + BIT_CLKS * 2 + BIT_CLKS / 2) begin
            chk_cnt++;
            if (tx8 !== 1'b1) $display("FAIL b2b_bit1: got %b want 1", tx8);
            else pass_cnt++;
         end
         if (n > 961 && if8.donetx === 1'b1) begin
            done_cnt++;
            done_at = n;
         end
      end
      chk_cnt++;
      if (done_cnt != 1 || done_at != 1920)
         $display("FAIL b2b_done2: got %0d pulses at %0d want 1 at 1920", done_cnt, done_at);
      else pass_cnt++;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_rx_8n1();
      rx8_frame(8'h3C, 1'b1, 1'b1);
      rx8_frame(8'h81, 1'b1, 1'b1);
      rx8_frame(8'hFF, 1'b1, 1'b1);
      rx8_frame(8'h00, 1'b1, 1'b1);
      repeat (200) @(negedge clk);
      chk_cnt++;
      if (q8.size() != 0) $display("FAIL rx8_missing: got %0d pending want 0", q8.size());
      else pass_cnt++;
   endtask

   task automatic test_parity_7e2();
      rx7_frame(7'h55, 1'b1);
      rx7_frame(7'h55, 1'b0);
      rx7_frame(7'h23, 1'b0);
      rx7_frame(7'h23, 1'b1);
      repeat (200) @(negedge clk);
      chk_cnt++;
      if (q7.size() != 0) $display("FAIL rx7_missing: got %0d pending want 0", q7.size());
      else pass_cnt++;
   endtask

   task automatic test_break();
      int c0;
      c0 = done8_cnt;
      rx8_frame(8'h5A, 1'b0, 1'b0);
      repeat (2000) @(negedge clk);
      chk_cnt++;
      if (done8_cnt != c0 + 1)
         $display("FAIL break_count: got %0d donerx want %0d", done8_cnt - c0, 1);
      else pass_cnt++;
      rx8 = 1'b1;
      repeat (50) @(negedge clk);
      rx8_frame(8'h11, 1'b1, 1'b1);
      repeat (200) @(negedge clk);
      chk_cnt++;
      if (q8.size() != 0 || done8_cnt != c0 + 2)
         $display("FAIL break_recover: got %0d pending %0d donerx want 0 and 2",
                  q8.size(), done8_cnt - c0);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      int c0;
      c0 = done8_cnt;
      @(negedge clk);
      rx8 = 1'b0;
      repeat (30) @(negedge clk);
      rx8 = 1'b1;
      repeat (300) @(negedge clk);
      chk_cnt++;
      if (done8_cnt != c0) $display("FAIL glitch: got %0d donerx want 0", done8_cnt - c0);
      else pass_cnt++;
      rx8_frame(8'hA5, 1'b1, 1'b1);
      repeat (200) @(negedge clk);
      chk_cnt++;
      if (q8.size() != 0) $display("FAIL glitch_after: got %0d pending want 0", q8.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_tx();
      @(negedge clk);
      if8.dintx = 8'h00;
      if8.newd  = 1'b1;
      @(posedge clk);
      #1 if8.newd = 1'b0;
      repeat (BIT_CLKS + 150) @(negedge clk);
      chk_cnt++;
      if ({tx8, if8.tx_busy} !== 2'b01)
         $display("FAIL midtx_pre: got tx/busy %b want 01", {tx8, if8.tx_busy});
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({tx8, if8.tx_busy} !== 2'b10)
         $display("FAIL midtx_reset: got tx/busy %b want 10", {tx8, if8.tx_busy});
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      test_tx(8'h96);
   endtask

`ifdef UART_LOOPBACK_EN
   task automatic test_loopback();
      exp_t e;
      bit tx_low;
      tx_low = 1'b0;
      loopback = 1'b1;
      e.ferr = 1'b0;
      e.perr = 1'b0;
      e.data = 9'h0C3;
      q8.push_back(e);
      @(negedge clk);
      if8.dintx = 8'hC3;
      if8.newd  = 1'b1;
      @(posedge clk);
      #1 if8.newd = 1'b0;
      for (int n = 0; n < 1100; n++) begin
         @(negedge clk);
         if (tx8 !== 1'b1) tx_low = 1'b1;
      end
      chk_cnt++;
      if (tx_low) $display("FAIL loop_txpin: got low on tx pin want constant 1");
      else pass_cnt++;
      chk_cnt++;
      if (q8.size() != 0) $display("FAIL loop_rx: got %0d pending want 0", q8.size());
      else pass_cnt++;
      loopback = 1'b0;
      repeat (5) @(negedge clk);
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      rx8       = 1'b1;
      rx7       = 1'b1;
      loopback  = 1'b0;
      if8.newd  = 1'b0;
      if8.dintx = '0;
      if7.newd  = 1'b0;
      if7.dintx = '0;
      test_reset();
      test_tx(8'hA5);
      test_back_to_back();
      test_rx_8n1();
      test_parity_7e2();
      test_break();
      test_glitch();
      test_reset_mid_tx();
`ifdef UART_LOOPBACK_EN
      test_loopback();
`endif
      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
